executs_muldiv: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit. It sits beside the single-cycle execute ALU and adds

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_iter_step.sv | 39 +++
 rtl/executs_muldiv.sv | 188 ++++++++++++++++++
 tb/tb_executs_muldiv.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the multi-cycle multiply/divide unit.
package muldiv_pkg;

  // Operation codes presented by the control unit.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } md_state_e;

  // Datapath step flavour.
  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  localparam int DEF_WIDTH = 32;

  // Counter width able to hold WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of the shared datapath: a shift-add multiply step or a
// restoring-divide step producing one quotient bit.
module muldiv_iter_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,      // upper product half / partial remainder
  input  logic             shift_in_i, // multiplier LSB / next dividend bit
  input  logic [WIDTH-1:0] operand_i,  // multiplicand / divisor magnitude
  input  step_mode_e       mode_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             bit_o       // product bit shifted out / quotient bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;

  // Compute both candidate updates and select by mode.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    acc_o   = '0;
    bit_o   = 1'b0;
    sum     = {1'b0, acc_i} + (shift_in_i ? {1'b0, operand_i} : '0);
    shifted = {acc_i, shift_in_i};
    if (mode_i == STEP_MUL) begin
      acc_o = sum[WIDTH:1];
      bit_o = sum[0];
    end else if (shifted >= {1'b0, operand_i}) begin
      // The true difference is below the divisor, so WIDTH bits hold it exactly.
      acc_o = shifted[WIDTH-1:0] - operand_i;
      bit_o = 1'b1;
    end else begin
      acc_o = shifted[WIDTH-1:0];
      bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/executs_muldiv.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Works on operand magnitudes and fixes signs in FINISH.
module executs_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FAST_MULT = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] Read_data_1,
  input  logic [WIDTH-1:0] Read_data_2,
  input  logic             flush,
  output logic             op_ready,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = cnt_width(WIDTH);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;      // upper product half / remainder
  logic [WIDTH-1:0] shreg_q, shreg_d;  // multiplier / dividend -> quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;    // multiplicand / divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;          // negate product / quotient
  logic             rem_neg_q, rem_neg_d;  // negate remainder
  logic             dbz_q, dbz_d;          // divisor was zero
  logic             done_q, done_d;
  logic             dbz_flag_q, dbz_flag_d;

  logic               is_mul_op, is_div_op, is_signed_op, accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] fast_prod, product, prod_fix;

  step_mode_e       step_mode;
  logic             step_in, step_bit;
  logic [WIDTH-1:0] step_acc;

  assign op_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_flag_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;

  // Decode the request and form operand magnitudes and the sign-corrected product.
  always_comb begin
    is_mul_op    = (op_code == MD_MULT) || (op_code == MD_MULTU);
    is_div_op    = (op_code == MD_DIV)  || (op_code == MD_DIVU);
    is_signed_op = (op_code == MD_MULT) || (op_code == MD_DIV);
    accept       = op_valid && op_ready && !flush;
    a_neg        = is_signed_op && Read_data_1[WIDTH-1];
    b_neg        = is_signed_op && Read_data_2[WIDTH-1];
    a_mag        = a_neg ? -Read_data_1 : Read_data_1;
    b_mag        = b_neg ? -Read_data_2 : Read_data_2;
    fast_prod    = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    product      = {acc_q, shreg_q};
    prod_fix     = neg_q ? -product : product;
    step_mode    = is_div_q ? STEP_DIV : STEP_MUL;
    step_in      = is_div_q ? shreg_q[WIDTH-1] : shreg_q[0];
  end

  muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
    .acc_i      (acc_q),
    .shift_in_i (step_in),
    .operand_i  (opnd_q),
    .mode_i     (step_mode),
    .acc_o      (step_acc),
    .bit_o      (step_bit)
  );

  // Next-state and datapath updates for IDLE -> RUN -> FINISH -> IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    shreg_d    = shreg_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    dbz_d      = dbz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_flag_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_code == MD_MTHI) begin
            hi_d = Read_data_1;
          end else if (op_code == MD_MTLO) begin
            lo_d = Read_data_1;
          end else if (is_mul_op || is_div_op) begin
            acc_d     = '0;
            shreg_d   = a_mag;
            opnd_d    = b_mag;
            is_div_d  = is_div_op;
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            dbz_d     = is_div_op && (Read_data_2 == '0);
            cnt_d     = CW'(WIDTH - 1);
            state_d   = RUN;
            if ((FAST_MULT != 0) && is_mul_op) begin
              {acc_d, shreg_d} = fast_prod;
              state_d          = FINISH;
            end
          end
        end
      end
      RUN: begin
        acc_d   = step_acc;
        shreg_d = is_div_q ? {shreg_q[WIDTH-2:0], step_bit}
                           : {step_bit, shreg_q[WIDTH-1:1]};
        if (cnt_q == '0) state_d = FINISH;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FINISH: begin
        state_d    = IDLE;
        done_d     = 1'b1;
        dbz_flag_d = dbz_q;
        if (is_div_q) begin
          // A zero divisor leaves the dividend in the remainder path; LO is forced.
          lo_d = dbz_q ? '1 : (neg_q ? -shreg_q : shreg_q);
          hi_d = rem_neg_q ? -acc_q : acc_q;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase

    // An abort discards the in-flight op without touching HI/LO.
    if (flush && (state_q != IDLE)) begin
      state_d    = IDLE;
      done_d     = 1'b0;
      dbz_flag_d = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
    end
  end

  // State and datapath registers, cleared asynchronously.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      shreg_q    <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      dbz_q      <= 1'b0;
      done_q     <= 1'b0;
      dbz_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      shreg_q    <= shreg_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      dbz_q      <= dbz_d;
      done_q     <= done_d;
      dbz_flag_q <= dbz_flag_d;
    end
  end

endmodule

// File: tb/tb_executs_muldiv.sv
// Directed self-checking bench: one iterative instance and one with the fast
// multiplier, driven from shared inputs.
module tb_executs_muldiv;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, op_valid, flush;
  logic [2:0]   op_code;
  logic [W-1:0] rd1, rd2;

  logic         op_ready, busy, done, div_by_zero;
  logic [W-1:0] hi_out, lo_out;
  logic         f_op_ready, f_busy, f_done, f_div_by_zero;
  logic [W-1:0] f_hi_out, f_lo_out;

  int total = 0;
  int bad   = 0;
  int edges, bcyc, seen;

  executs_muldiv #(.WIDTH(W), .FAST_MULT(0)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .Read_data_1(rd1), .Read_data_2(rd2), .flush(flush),
    .op_ready(op_ready), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  executs_muldiv #(.WIDTH(W), .FAST_MULT(1)) dut_fast (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .Read_data_1(rd1), .Read_data_2(rd2), .flush(flush),
    .op_ready(f_op_ready), .busy(f_busy), .done(f_done), .div_by_zero(f_div_by_zero),
    .hi_out(f_hi_out), .lo_out(f_lo_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns 1 time unit after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    op_valid = 1'b1;
    op_code  = op;
    rd1      = a;
    rd2      = b;
    @(posedge clock);
    #1 op_valid = 1'b0;
  endtask

  // Count edges after the accept edge until done is seen (bounded).
  task automatic wait_done(input int max, output int n_edges, output int n_busy);
    n_busy  = busy ? 1 : 0;
    n_edges = 0;
    while (n_edges < max) begin
      @(posedge clock);
      #1;
      n_edges++;
      if (busy) n_busy++;
      if (done) break;
    end
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; flush = 1'b0; op_code = '0; rd1 = '0; rd2 = '0;
    #12;
    check("rst_hi", hi_out, 0);
    check("rst_lo", lo_out, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", op_ready, 1);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clock);
    reset = 1'b0;

    // multu max*max
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_ready_busy", op_ready, 0);
    wait_done(60, edges, bcyc);
    check("multu_latency", edges, 33);
    check("multu_busy_cycles", bcyc, 33);
    check("multu_done", done, 1);
    check("multu_hi", hi_out, 64'hFFFFFFFE);
    check("multu_lo", lo_out, 64'h00000001);
    check("multu_dbz", div_by_zero, 0);
    @(posedge clock); #1;
    check("done_one_cycle", done, 0);

    // signed mult -3*5, fast instance finishes after one edge
    issue(MD_MULT, 32'hFFFFFFFD, 32'd5);
    @(posedge clock); #1;
    check("fast_mult_done", f_done, 1);
    check("fast_mult_hi", f_hi_out, 64'hFFFFFFFF);
    check("fast_mult_lo", f_lo_out, 64'hFFFFFFF1);
    check("slow_still_busy", busy, 1);
    wait_done(60, edges, bcyc);
    check("mult_latency_rest", edges, 32);
    check("mult_hi", hi_out, 64'hFFFFFFFF);
    check("mult_lo", lo_out, 64'hFFFFFFF1);

    // div -7/2
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(60, edges, bcyc);
    check("div_done", done, 1);
    check("div_lo", lo_out, 64'hFFFFFFFD);
    check("div_hi", hi_out, 64'hFFFFFFFF);

    // div MIN / -1 wraps
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(60, edges, bcyc);
    check("divmin_lo", lo_out, 64'h80000000);
    check("divmin_hi", hi_out, 0);
    check("divmin_dbz", div_by_zero, 0);

    // divu 5/0 with an mtlo request held while busy
    issue(MD_DIVU, 32'd5, 32'd0);
    op_valid = 1'b1; op_code = MD_MTLO; rd1 = 32'h1234; rd2 = '0;
    check("held_not_ready", op_ready, 0);
    wait_done(60, edges, bcyc);
    check("dbz_latency", edges, 33);
    check("dbz_flag", div_by_zero, 1);
    check("dbz_hi", hi_out, 64'd5);
    check("dbz_lo", lo_out, 64'hFFFFFFFF);
    @(posedge clock); #1;
    op_valid = 1'b0;
    check("mtlo_lo", lo_out, 64'h1234);
    check("mtlo_hi_kept", hi_out, 64'd5);
    check("mtlo_no_done", done, 0);
    check("dbz_clears", div_by_zero, 0);

    // op code outside the enum is ignored
    issue(3'd7, 32'd1, 32'd2);
    check("badop_busy", busy, 0);
    check("badop_hi", hi_out, 64'd5);

    // mthi, then a flushed div
    issue(MD_MTHI, 32'hAAAA0000, 32'd0);
    check("mthi_hi", hi_out, 64'hAAAA0000);
    check("mthi_no_busy", busy, 0);
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    check("flush_idle", busy, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) seen++;
    end
    check("flush_no_done", seen, 0);
    check("flush_hi_kept", hi_out, 64'hAAAA0000);
    check("flush_lo_kept", lo_out, 64'h1234);

    // flush in IDLE blocks a same-cycle accept
    @(negedge clock);
    flush = 1'b1; op_valid = 1'b1; op_code = MD_MTHI; rd1 = 32'h5555;
    @(posedge clock);
    #1 begin op_valid = 1'b0; flush = 1'b0; end
    check("idle_flush_blocks", hi_out, 64'hAAAA0000);

    issue(MD_DIVU, 32'd100, 32'd7);
    wait_done(60, edges, bcyc);
    check("divu_lo", lo_out, 64'd14);
    check("divu_hi", hi_out, 64'd2);

    // asynchronous reset mid-RUN
    issue(MD_MULTU, 32'd3, 32'd3);
    repeat (5) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("arst_hi", hi_out, 0);
    check("arst_lo", lo_out, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", op_ready, 1);
    @(negedge clock);
    reset = 1'b0;

    issue(MD_MULT, 32'd6, 32'd7);
    @(posedge clock); #1;
    check("fast_6x7_lo", f_lo_out, 64'd42);
    wait_done(60, edges, bcyc);
    check("mult_6x7_done", done, 1);
    check("mult_6x7_lo", lo_out, 64'd42);
    check("mult_6x7_hi", hi_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
